// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order dual-way issue controller for the decode stage.
// Tracks registers with a pending long-latency write (loads, mul/div) and the
// occupancy of the single multiply unit, and decides per cycle which of the
// two decoded instructions may issue.
// Optional feature macro: DUAL_ISSUE_EN. When undefined, way1 never issues and
// the core runs single-issue through way0.
module issue_scoreboard #(
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        way0Valid_i,
  input  logic [4:0]  way0Rs1Addr_i,
  input  logic [4:0]  way0Rs2Addr_i,
  input  logic        way0Rs1ReadEnable_i,
  input  logic        way0Rs2ReadEnable_i,
  input  logic [4:0]  way0RdAddr_i,
  input  logic        way0RdValid_i,
  input  logic        way0IsLoad_i,
  input  logic        way0IsMul_i,
  input  logic        way1Valid_i,
  input  logic [4:0]  way1Rs1Addr_i,
  input  logic [4:0]  way1Rs2Addr_i,
  input  logic        way1Rs1ReadEnable_i,
  input  logic        way1Rs2ReadEnable_i,
  input  logic [4:0]  way1RdAddr_i,
  input  logic        way1RdValid_i,
  input  logic        way1IsLoad_i,
  input  logic        way1IsMul_i,
  input  logic        exReady_i,
  input  logic        flush_i,
  input  logic        wb0Valid_i,
  input  logic [4:0]  wb0Addr_i,
  input  logic        wb1Valid_i,
  input  logic [4:0]  wb1Addr_i,
  output logic        way0Issue_o,
  output logic        way1Issue_o,
  output logic        idStall_o,
  output logic [31:0] busyVec_o,
  output logic        mulBusy_o
);

  // Pending-write bits; bit 0 is never set because x0 is never tracked.
  logic [31:0]      r_busy;
  logic [CNT_W-1:0] r_mul_cnt;

  logic        w_mul_busy;
  logic        w_ll0;
  logic        w_h0;
  logic        w_issue0;
  logic        w_ll1;
  logic        w_issue1;
  logic        w_mul_issue;
  logic [31:0] w_release;
  logic [31:0] w_set;

  assign w_mul_busy = (r_mul_cnt != '0);

  // Only loads and M-extension ops writing a real register are tracked;
  // ALU results are covered by forwarding.
  assign w_ll0 = way0RdValid_i & (way0IsLoad_i | way0IsMul_i) & (way0RdAddr_i != 5'd0);

  assign w_h0 = (way0Rs1ReadEnable_i & r_busy[way0Rs1Addr_i])
              | (way0Rs2ReadEnable_i & r_busy[way0Rs2Addr_i])
              | (w_ll0 & r_busy[way0RdAddr_i])
              | (way0IsMul_i & w_mul_busy);

  assign w_issue0 = way0Valid_i & exReady_i & ~flush_i & ~w_h0;

`ifdef DUAL_ISSUE_EN
  logic w_h1_own;
  logic w_h1_pair;

  assign w_ll1 = way1RdValid_i & (way1IsLoad_i | way1IsMul_i) & (way1RdAddr_i != 5'd0);

  assign w_h1_own = (way1Rs1ReadEnable_i & r_busy[way1Rs1Addr_i])
                  | (way1Rs2ReadEnable_i & r_busy[way1Rs2Addr_i])
                  | (w_ll1 & r_busy[way1RdAddr_i])
                  | (way1IsMul_i & w_mul_busy);

  // Dependencies inside the pair, plus the single multiplier and single LSU port.
  assign w_h1_pair = (way0RdValid_i & (way0RdAddr_i != 5'd0) &
                       ((way1Rs1ReadEnable_i & (way1Rs1Addr_i == way0RdAddr_i)) |
                        (way1Rs2ReadEnable_i & (way1Rs2Addr_i == way0RdAddr_i)) |
                        (way1RdValid_i & (way1RdAddr_i == way0RdAddr_i))))
                   | (way0IsMul_i & way1IsMul_i)
                   | (way0IsLoad_i & way1IsLoad_i);

  // In-order: way1 can only follow an issuing way0.
  assign w_issue1 = w_issue0 & way1Valid_i & ~w_h1_own & ~w_h1_pair;
`else
  logic w_unused_way1;

  assign w_unused_way1 = ^{way1Rs1Addr_i, way1Rs2Addr_i, way1Rs1ReadEnable_i,
                           way1Rs2ReadEnable_i, way1RdAddr_i, way1RdValid_i,
                           way1IsLoad_i, way1IsMul_i};
  assign w_ll1    = 1'b0;
  assign w_issue1 = 1'b0;
`endif

  assign w_mul_issue = (w_issue0 & way0IsMul_i) | (w_issue1 & way1IsMul_i);

  // Per-register release/set decode; x0 is never released or set.
  assign w_release[0] = 1'b0;
  assign w_set[0]     = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      assign w_release[gi] = (wb0Valid_i & (wb0Addr_i == 5'(gi)))
                           | (wb1Valid_i & (wb1Addr_i == 5'(gi)));
      assign w_set[gi]     = (w_issue0 & w_ll0 & (way0RdAddr_i == 5'(gi)))
                           | (w_issue1 & w_ll1 & (way1RdAddr_i == 5'(gi)));
    end
  endgenerate

  // Pending-write tracking: set overrides a same-cycle release (newer write).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else if (flush_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_release) | w_set;
    end
  end

  // Multiply occupancy: reload on a mul issue, otherwise count down to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mul_cnt <= '0;
    end else if (flush_i) begin
      r_mul_cnt <= '0;
    end else if (w_mul_issue) begin
      r_mul_cnt <= CNT_W'(MUL_LATENCY);
    end else if (w_mul_busy) begin
      r_mul_cnt <= r_mul_cnt - 1'b1;
    end
  end

  assign way0Issue_o = w_issue0;
  assign way1Issue_o = w_issue1;
  assign idStall_o   = (way0Valid_i & ~w_issue0) | (way1Valid_i & ~w_issue1);
  assign busyVec_o   = r_busy;
  assign mulBusy_o   = w_mul_busy;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Testbench for issue_scoreboard: table-driven vectors from reset, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_issue_scoreboard;

  localparam int MUL_LAT = 3;
`ifdef DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       re1;
    logic       re2;
    logic [4:0] rd;
    logic       rdv;
    logic       ld;
    logic       mul;
  } way_t;

  typedef struct packed {
    way_t       w0;
    way_t       w1;
    logic       exr;
    logic       fl;
    logic       wb0v;
    logic [4:0] wb0a;
    logic       wb1v;
    logic [4:0] wb1a;
  } in_t;

  typedef struct {
    in_t         x;
    bit          e0;
    bit          e1d;
    bit          st_d;
    bit          st_s;
    logic [31:0] busy_d;
    logic [31:0] busy_s;
    bit          mb;
  } tv_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic way0Valid_i = 0, way0Rs1ReadEnable_i = 0, way0Rs2ReadEnable_i = 0;
  logic way0RdValid_i = 0, way0IsLoad_i = 0, way0IsMul_i = 0;
  logic [4:0] way0Rs1Addr_i = 0, way0Rs2Addr_i = 0, way0RdAddr_i = 0;
  logic way1Valid_i = 0, way1Rs1ReadEnable_i = 0, way1Rs2ReadEnable_i = 0;
  logic way1RdValid_i = 0, way1IsLoad_i = 0, way1IsMul_i = 0;
  logic [4:0] way1Rs1Addr_i = 0, way1Rs2Addr_i = 0, way1RdAddr_i = 0;
  logic exReady_i = 0, flush_i = 0, wb0Valid_i = 0, wb1Valid_i = 0;
  logic [4:0] wb0Addr_i = 0, wb1Addr_i = 0;
  logic way0Issue_o, way1Issue_o, idStall_o, mulBusy_o;
  logic [31:0] busyVec_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: which registers await a long-latency result, and how
  // many more cycles the multiplier stays occupied.
  bit m_busy[32];
  int m_cnt;

  issue_scoreboard #(.MUL_LATENCY(MUL_LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .way0Valid_i(way0Valid_i), .way0Rs1Addr_i(way0Rs1Addr_i), .way0Rs2Addr_i(way0Rs2Addr_i),
    .way0Rs1ReadEnable_i(way0Rs1ReadEnable_i), .way0Rs2ReadEnable_i(way0Rs2ReadEnable_i),
    .way0RdAddr_i(way0RdAddr_i), .way0RdValid_i(way0RdValid_i),
    .way0IsLoad_i(way0IsLoad_i), .way0IsMul_i(way0IsMul_i),
    .way1Valid_i(way1Valid_i), .way1Rs1Addr_i(way1Rs1Addr_i), .way1Rs2Addr_i(way1Rs2Addr_i),
    .way1Rs1ReadEnable_i(way1Rs1ReadEnable_i), .way1Rs2ReadEnable_i(way1Rs2ReadEnable_i),
    .way1RdAddr_i(way1RdAddr_i), .way1RdValid_i(way1RdValid_i),
    .way1IsLoad_i(way1IsLoad_i), .way1IsMul_i(way1IsMul_i),
    .exReady_i(exReady_i), .flush_i(flush_i),
    .wb0Valid_i(wb0Valid_i), .wb1Valid_i(wb1Valid_i),
    .wb0Addr_i(wb0Addr_i), .wb1Addr_i(wb1Addr_i),
    .way0Issue_o(way0Issue_o), .way1Issue_o(way1Issue_o), .idStall_o(idStall_o),
    .busyVec_o(busyVec_o), .mulBusy_o(mulBusy_o)
  );

  always #5 clk = ~clk;

  function automatic way_t mk_none();
    way_t w = '0;
    return w;
  endfunction

  function automatic way_t mk_ld(input int rd, input int rs1);
    way_t w = '0;
    w.v = 1; w.rs1 = 5'(rs1); w.re1 = 1; w.rd = 5'(rd); w.rdv = 1; w.ld = 1;
    return w;
  endfunction

  function automatic way_t mk_alu(input int rd, input int rs1, input int rs2);
    way_t w = '0;
    w.v = 1; w.rs1 = 5'(rs1); w.rs2 = 5'(rs2); w.re1 = 1; w.re2 = 1;
    w.rd = 5'(rd); w.rdv = 1;
    return w;
  endfunction

  function automatic way_t mk_mul(input int rd, input int rs1, input int rs2);
    way_t w = mk_alu(rd, rs1, rs2);
    w.mul = 1;
    return w;
  endfunction

  function automatic in_t mk_in(input way_t a, input way_t b);
    in_t x = '0;
    x.w0 = a; x.w1 = b; x.exr = 1;
    return x;
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit is_ll(input way_t w);
    return w.rdv && (w.ld || w.mul) && (w.rd != 0);
  endfunction

  // Hazards of one instruction against outstanding work.
  function automatic bit own_hazard(input way_t w);
    bit h = 0;
    if (w.re1 && m_busy[w.rs1]) h = 1;
    if (w.re2 && m_busy[w.rs2]) h = 1;
    if (is_ll(w) && m_busy[w.rd]) h = 1;
    if (w.mul && m_cnt > 0) h = 1;
    return h;
  endfunction

  // Hazards of the younger instruction against the older one in the pair.
  function automatic bit pair_hazard(input way_t a, input way_t b);
    bit h = 0;
    if (a.rdv && a.rd != 0) begin
      if (b.re1 && b.rs1 == a.rd) h = 1;
      if (b.re2 && b.rs2 == a.rd) h = 1;
      if (b.rdv && b.rd == a.rd) h = 1;
    end
    if (a.mul && b.mul) h = 1;
    if (a.ld && b.ld) h = 1;
    return h;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_cnt = 0;
  endtask

  task automatic model_eval(input in_t x, output bit e0, output bit e1, output bit est);
    e0 = x.w0.v && x.exr && !x.fl && !own_hazard(x.w0);
    e1 = DUAL && e0 && x.w1.v && !own_hazard(x.w1) && !pair_hazard(x.w0, x.w1);
    est = (x.w0.v && !e0) || (x.w1.v && !e1);
  endtask

  task automatic model_commit(input in_t x, input bit e0, input bit e1);
    if (x.fl) begin
      model_clear();
    end else begin
      if (x.wb0v) m_busy[x.wb0a] = 0;
      if (x.wb1v) m_busy[x.wb1a] = 0;
      m_busy[0] = 0;
      if (e0 && is_ll(x.w0)) m_busy[x.w0.rd] = 1;
      if (e1 && is_ll(x.w1)) m_busy[x.w1.rd] = 1;
      if ((e0 && x.w0.mul) || (e1 && x.w1.mul)) m_cnt = MUL_LAT;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t x);
    way0Valid_i = x.w0.v; way0Rs1Addr_i = x.w0.rs1; way0Rs2Addr_i = x.w0.rs2;
    way0Rs1ReadEnable_i = x.w0.re1; way0Rs2ReadEnable_i = x.w0.re2;
    way0RdAddr_i = x.w0.rd; way0RdValid_i = x.w0.rdv;
    way0IsLoad_i = x.w0.ld; way0IsMul_i = x.w0.mul;
    way1Valid_i = x.w1.v; way1Rs1Addr_i = x.w1.rs1; way1Rs2Addr_i = x.w1.rs2;
    way1Rs1ReadEnable_i = x.w1.re1; way1Rs2ReadEnable_i = x.w1.re2;
    way1RdAddr_i = x.w1.rd; way1RdValid_i = x.w1.rdv;
    way1IsLoad_i = x.w1.ld; way1IsMul_i = x.w1.mul;
    exReady_i = x.exr; flush_i = x.fl;
    wb0Valid_i = x.wb0v; wb0Addr_i = x.wb0a; wb1Valid_i = x.wb1v; wb1Addr_i = x.wb1a;
  endtask

  // One cycle: drive at posedge+1, compare at negedge, advance model after the edge.
  task automatic step(input in_t x, input string tag, output logic a0, output logic a1, output logic ast);
    bit e0, e1, est;
    apply(x);
    @(negedge clk);
    model_eval(x, e0, e1, est);
    a0 = way0Issue_o; a1 = way1Issue_o; ast = idStall_o;
    chk({tag, ".issue0"}, 32'(way0Issue_o), 32'(e0));
    chk({tag, ".issue1"}, 32'(way1Issue_o), 32'(e1));
    chk({tag, ".stall"}, 32'(idStall_o), 32'(est));
    chk({tag, ".busyVec"}, busyVec_o, model_vec());
    chk({tag, ".mulBusy"}, 32'(mulBusy_o), 32'(m_cnt > 0));
    $display("[%0t] %s v=%b%b ex=%b fl=%b -> i0=%b i1=%b st=%b busy=%h mb=%b",
             $time, tag, x.w0.v, x.w1.v, x.exr, x.fl, way0Issue_o, way1Issue_o,
             idStall_o, busyVec_o, mulBusy_o);
    @(posedge clk);
    #1;
    model_commit(x, e0, e1);
  endtask

  task automatic do_reset();
    apply('0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.issue0", 32'(way0Issue_o), 32'd0);
    chk("rst.issue1", 32'(way1Issue_o), 32'd0);
    chk("rst.stall", 32'(idStall_o), 32'd0);
    chk("rst.busyVec", busyVec_o, 32'd0);
    chk("rst.mulBusy", 32'(mulBusy_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  tv_t tv[11];

  initial begin
    logic a0, a1, ast;
    in_t x;

    // Each vector starts from a freshly reset scoreboard.
    tv[0]  = '{mk_in(mk_ld(5, 1),     mk_alu(6, 1, 2)),  1, 1, 0, 1, 32'h20,   32'h20,   0};
    tv[1]  = '{mk_in(mk_alu(3, 1, 1), mk_alu(7, 3, 4)),  1, 0, 1, 1, 32'h0,    32'h0,    0};
    tv[2]  = '{mk_in(mk_ld(8, 2),     mk_ld(9, 2)),      1, 0, 1, 1, 32'h100,  32'h100,  0};
    tv[3]  = '{mk_in(mk_mul(10, 1, 2), mk_mul(11, 3, 4)), 1, 0, 1, 1, 32'h400, 32'h400,  1};
    tv[4]  = '{mk_in(mk_ld(5, 1),     mk_none()),        0, 0, 1, 1, 32'h0,    32'h0,    0};
    tv[4].x.exr = 0;
    tv[5]  = '{mk_in(mk_ld(5, 1),     mk_alu(6, 1, 2)),  0, 0, 1, 1, 32'h0,    32'h0,    0};
    tv[5].x.fl = 1;
    tv[6]  = '{mk_in(mk_ld(12, 1),    mk_alu(12, 2, 3)), 1, 0, 1, 1, 32'h1000, 32'h1000, 0};
    tv[7]  = '{mk_in(mk_ld(0, 1),     mk_alu(4, 0, 0)),  1, 1, 0, 1, 32'h0,    32'h0,    0};
    tv[8]  = '{mk_in(mk_none(),       mk_alu(6, 1, 2)),  0, 0, 1, 1, 32'h0,    32'h0,    0};
    tv[9]  = '{mk_in(mk_none(),       mk_none()),        0, 0, 0, 0, 32'h0,    32'h0,    0};
    tv[10] = '{mk_in(mk_mul(4, 1, 2), mk_ld(5, 3)),      1, 1, 0, 1, 32'h30,   32'h10,   1};

    for (int i = 0; i < 11; i++) begin
      do_reset();
      step(tv[i].x, $sformatf("tv%0d", i), a0, a1, ast);
      chk($sformatf("tv%0d.i0", i), 32'(a0), 32'(tv[i].e0));
      chk($sformatf("tv%0d.i1", i), 32'(a1), 32'(DUAL ? tv[i].e1d : 1'b0));
      chk($sformatf("tv%0d.st", i), 32'(ast), 32'(DUAL ? tv[i].st_d : tv[i].st_s));
      chk($sformatf("tv%0d.busy", i), busyVec_o, DUAL ? tv[i].busy_d : tv[i].busy_s);
      chk($sformatf("tv%0d.mb", i), 32'(mulBusy_o), 32'(tv[i].mb));
    end

    // RAW on a pending load: the writeback cycle still stalls, the next issues.
    do_reset();
    step(mk_in(mk_ld(5, 1), mk_none()), "raw.ld", a0, a1, ast);
    x = mk_in(mk_alu(6, 5, 1), mk_none());
    x.wb0v = 1; x.wb0a = 5;
    step(x, "raw.wb", a0, a1, ast);
    chk("raw.wb.i0", 32'(a0), 32'd0);
    chk("raw.wb.st", 32'(ast), 32'd1);
    step(mk_in(mk_alu(6, 5, 1), mk_none()), "raw.after", a0, a1, ast);
    chk("raw.after.i0", 32'(a0), 32'd1);

    // Multiplier structural hazard over MUL_LATENCY cycles.
    do_reset();
    step(mk_in(mk_mul(7, 1, 2), mk_none()), "mul.T", a0, a1, ast);
    chk("mul.T.i0", 32'(a0), 32'd1);
    for (int k = 1; k <= MUL_LAT; k++) begin
      chk($sformatf("mul.T+%0d.mb", k), 32'(mulBusy_o), 32'd1);
      step(mk_in(mk_mul(8, 1, 2), mk_none()), $sformatf("mul.T+%0d", k), a0, a1, ast);
      chk($sformatf("mul.T+%0d.i0", k), 32'(a0), 32'd0);
    end
    chk("mul.T+4.mb", 32'(mulBusy_o), 32'd0);
    step(mk_in(mk_mul(8, 1, 2), mk_none()), "mul.T+4", a0, a1, ast);
    chk("mul.T+4.i0", 32'(a0), 32'd1);

    // Same-cycle set and release of x9: the new write stays pending.
    do_reset();
    x = mk_in(mk_ld(9, 1), mk_none());
    x.wb1v = 1; x.wb1a = 9;
    step(x, "setwin", a0, a1, ast);
    chk("setwin.bit9", 32'(busyVec_o[9]), 32'd1);

    // Fill every register and occupy the multiplier, then flush.
    do_reset();
    for (int r = 1; r <= 30; r++) step(mk_in(mk_ld(r, 0), mk_none()), $sformatf("fill.x%0d", r), a0, a1, ast);
    step(mk_in(mk_mul(31, 0, 0), mk_none()), "fill.mul", a0, a1, ast);
    step(mk_in(mk_none(), mk_none()), "fill.idle", a0, a1, ast);
    chk("flush.pre.busy", busyVec_o, 32'hFFFF_FFFE);
    chk("flush.pre.mb", 32'(mulBusy_o), 32'd1);
    x = mk_in(mk_alu(1, 0, 0), mk_alu(2, 0, 0));
    x.fl = 1;
    step(x, "flush", a0, a1, ast);
    chk("flush.i0", 32'(a0), 32'd0);
    chk("flush.i1", 32'(a1), 32'd0);
    chk("flush.post.busy", busyVec_o, 32'd0);
    chk("flush.post.mb", 32'(mulBusy_o), 32'd0);

    // Reset asserted mid-operation drops pending bits immediately.
    do_reset();
    step(mk_in(mk_ld(5, 1), mk_mul(6, 2, 3)), "async.pre", a0, a1, ast);
    apply('0);
    #2;
    rst = 1'b0;
    #1;
    chk("async.busy", busyVec_o, 32'd0);
    chk("async.mb", 32'(mulBusy_o), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      way_t w[2];
      for (int j = 0; j < 2; j++) begin
        int kind;
        w[j] = '0;
        w[j].v   = ($urandom_range(0, 3) != 0);
        w[j].rs1 = 5'($urandom_range(0, 7));
        w[j].rs2 = 5'($urandom_range(0, 7));
        w[j].re1 = 1'($urandom_range(0, 1));
        w[j].re2 = 1'($urandom_range(0, 1));
        w[j].rd  = 5'($urandom_range(0, 7));
        w[j].rdv = ($urandom_range(0, 3) != 0);
        kind = $urandom_range(0, 5);
        w[j].ld  = (kind < 2);
        w[j].mul = (kind == 2);
      end
      x = mk_in(w[0], w[1]);
      x.exr  = ($urandom_range(0, 7) != 0);
      x.fl   = ($urandom_range(0, 31) == 0);
      x.wb0v = ($urandom_range(0, 2) == 0);
      x.wb0a = 5'($urandom_range(0, 7));
      x.wb1v = ($urandom_range(0, 2) == 0);
      x.wb1a = 5'($urandom_range(0, 7));
      step(x, $sformatf("rnd%0d", n), a0, a1, ast);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
